// File: rtl/axis_egress_buf.sv
// rtl/axis_egress_buf.sv - AXI4-Stream egress buffer with optional store-and-forward release
module axis_egress_buf #(
   parameter int DATA_WIDTH  = 64,
   parameter int USER_WIDTH  = 1,
   parameter int DEPTH       = 8,
   parameter int PACKET_MODE = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_WIDTH-1:0]    s_tdata,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   input  logic                     s_tlast,
   input  logic [USER_WIDTH-1:0]    s_tuser,
   output logic [DATA_WIDTH-1:0]    m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic                     m_tlast,
   output logic [USER_WIDTH-1:0]    m_tuser,
   output logic [$clog2(DEPTH):0]   level,
   output logic [$clog2(DEPTH):0]   pkt_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_WIDTH + 1 + USER_WIDTH;
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          push_last;
   logic          pop_last;

   assign full     = (level == FULL_LVL);
   assign empty    = (level == '0);
   assign s_tready = !full;

   // Full acts as a release so packets longer than DEPTH cannot deadlock store-and-forward.
   assign m_tvalid = !empty && ((PACKET_MODE == 0) || (pkt_count != '0) || full);

   assign push      = s_tvalid && s_tready;
   assign pop       = m_tvalid && m_tready;
   assign push_last = push && s_tlast;
   assign pop_last  = pop && m_tlast;

   assign {m_tdata, m_tlast, m_tuser} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {s_tdata, s_tlast, s_tuser};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         pkt_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            level <= level + LVL_ONE;
         end else if (pop && !push) begin
            level <= level - LVL_ONE;
         end
         if (push_last && !pop_last) begin
            pkt_count <= pkt_count + LVL_ONE;
         end else if (pop_last && !push_last) begin
            pkt_count <= pkt_count - LVL_ONE;
         end
      end
   end

endmodule
